// File: rtl/req_encoder_4_2.sv
// Sticky request collector: latches request lines into a pending set and hands out
// one binary index per valid/ready handshake, with fixed-priority or round-robin pick.
module req_encoder_4_2 #(
  parameter int N    = 4,
  parameter int MODE = 0,
  parameter int CW   = 4,
  localparam int W   = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          e,
  input  logic [N-1:0]  y,
  input  logic          ready,
  output logic [W-1:0]  w,
  output logic          valid,
  output logic          multi,
  output logic [CW-1:0] drop_cnt
);

  localparam int unsigned DMAX = (2 ** CW) - 1;

  logic [N-1:0]  pending_q, pending_d;
  logic [W-1:0]  w_q, w_d;
  logic          valid_q, valid_d;
  logic          multi_q, multi_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [W-1:0]  last_q, last_d;

  logic [N-1:0]  y_m;
  logic [N-1:0]  grant_mask;
  logic [N-1:0]  drop_bits;
  logic [W-1:0]  sel;
  logic          found;
  logic          slot_free;
  logic          grant;

  // y is masked first so undefined lines while e=0 never reach state
  assign y_m       = e ? y : '0;
  assign slot_free = !valid_q || ready;

  always_comb begin
    int unsigned idx;
    logic [W-1:0] idx_w;
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    idx_w = '0;
    for (int k = 0; k < N; k++) begin
      if (MODE == 1) idx = (int'(last_q) + 1 + k) % N;
      else           idx = k;
      idx_w = W'(idx);
      if (!found && pending_q[idx_w]) begin
        found = 1'b1;
        sel   = idx_w;
      end
    end
  end

  assign grant      = slot_free && found;
  assign grant_mask = grant ? (N'(1) << sel) : '0;
  // a request for the index granted on this edge re-arms it rather than counting as lost
  assign drop_bits  = y_m & pending_q & ~grant_mask;

  always_comb begin
    int unsigned sum;
    pending_d = (pending_q & ~grant_mask) | y_m;
    w_d       = w_q;
    valid_d   = valid_q;
    last_d    = last_q;
    if (grant) begin
      w_d     = sel;
      valid_d = 1'b1;
      last_d  = sel;
    end else if (slot_free) begin
      valid_d = 1'b0;
    end
    multi_d = ($countones(y_m) >= 2);
    sum     = int'(drop_q) + $countones(drop_bits);
    drop_d  = (sum > DMAX) ? CW'(DMAX) : CW'(sum);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      w_q       <= '0;
      valid_q   <= 1'b0;
      multi_q   <= 1'b0;
      drop_q    <= '0;
      last_q    <= W'(N - 1);
    end else begin
      pending_q <= pending_d;
      w_q       <= w_d;
      valid_q   <= valid_d;
      multi_q   <= multi_d;
      drop_q    <= drop_d;
      last_q    <= last_d;
    end
  end

  assign w        = w_q;
  assign valid    = valid_q;
  assign multi    = multi_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_req_encoder_4_2.sv
// Bench for req_encoder_4_2: three instances (fixed priority, round-robin, 2-bit drop
// counter) share stimulus; a reference model feeds per-instance scoreboards.
module tb_req_encoder_4_2;

  logic       clk;
  logic       rst_n;
  logic       e;
  logic [3:0] y;
  logic       ready;

  logic [1:0] w0, w1, w2;
  logic       vld0, vld1, vld2;
  logic       mul0, mul1, mul2;
  logic [3:0] dc0, dc1;
  logic [1:0] dc2;

  req_encoder_4_2 #(.N(4), .MODE(0), .CW(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .e(e), .y(y), .ready(ready),
    .w(w0), .valid(vld0), .multi(mul0), .drop_cnt(dc0));
  req_encoder_4_2 #(.N(4), .MODE(1), .CW(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .e(e), .y(y), .ready(ready),
    .w(w1), .valid(vld1), .multi(mul1), .drop_cnt(dc1));
  req_encoder_4_2 #(.N(4), .MODE(0), .CW(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .e(e), .y(y), .ready(ready),
    .w(w2), .valid(vld2), .multi(mul2), .drop_cnt(dc2));

  int a_w [3];
  int a_v [3];
  int a_m [3];
  int a_d [3];
  always_comb begin
    a_w[0] = int'(w0);   a_w[1] = int'(w1);   a_w[2] = int'(w2);
    a_v[0] = int'(vld0); a_v[1] = int'(vld1); a_v[2] = int'(vld2);
    a_m[0] = int'(mul0); a_m[1] = int'(mul1); a_m[2] = int'(mul2);
    a_d[0] = int'(dc0);  a_d[1] = int'(dc1);  a_d[2] = int'(dc2);
  end

  int checks = 0;
  int errors = 0;

  // reference model state, one slot per instance
  int MODE_T [3] = '{0, 1, 0};
  int DMAX_T [3] = '{15, 15, 3};
  bit [3:0] m_pend [3];
  int m_valid [3];
  int m_last  [3];
  int m_drop  [3];
  int m_multi [3];
  int q0[$];
  int q1[$];
  int q2[$];

  bit mon_en = 0;
  bit pv [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string name, input int k, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s[inst %0d] actual=%0d expected=%0d t=%0t", name, k, act, exp, $time);
    end
  endtask

  function automatic void sb_push(input int k, input int code);
    case (k)
      0: q0.push_back(code);
      1: q1.push_back(code);
      default: q2.push_back(code);
    endcase
  endfunction

  function automatic bit sb_pop(input int k, output int code);
    code = -1;
    case (k)
      0: if (q0.size() == 0) return 0; else code = q0.pop_front();
      1: if (q1.size() == 0) return 0; else code = q1.pop_front();
      default: if (q2.size() == 0) return 0; else code = q2.pop_front();
    endcase
    return 1;
  endfunction

  function automatic int sb_size(input int k);
    case (k)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      m_pend[k] = 4'b0; m_valid[k] = 0; m_last[k] = 3;
      m_drop[k] = 0;    m_multi[k] = 0; pv[k] = 0;
    end
    q0.delete(); q1.delete(); q2.delete();
  endfunction

  // what the upcoming rising edge does, given the inputs now on e/y/ready
  function automatic void model_eval(input int k);
    int gi, drops, idx, nones;
    bit slot_free;
    slot_free = (m_valid[k] == 0) || (ready == 1'b1);
    gi = -1;
    if (slot_free)
      for (int off = 0; off < 4; off++) begin
        idx = (MODE_T[k] == 1) ? (m_last[k] + 1 + off) % 4 : off;
        if (gi < 0 && m_pend[k][idx]) gi = idx;
      end
    drops = 0;
    nones = 0;
    if (e == 1'b1)
      for (int i = 0; i < 4; i++)
        if (y[i] === 1'b1) begin
          nones++;
          if (m_pend[k][i] && i != gi) drops++;
        end
    m_multi[k] = (nones >= 2) ? 1 : 0;
    if (gi >= 0) begin
      m_pend[k][gi] = 1'b0;
      m_valid[k] = 1;
      m_last[k]  = gi;
      sb_push(k, gi);
    end else if (slot_free) begin
      m_valid[k] = 0;
    end
    if (e == 1'b1) m_pend[k] = m_pend[k] | y;
    m_drop[k] = (m_drop[k] + drops > DMAX_T[k]) ? DMAX_T[k] : m_drop[k] + drops;
  endfunction

  task automatic step(input bit ee, input logic [3:0] yy, input bit rr);
    @(negedge clk);
    e = ee; y = ee ? yy : 4'bxxxx; ready = rr;
    for (int k = 0; k < 3; k++) model_eval(k);
  endtask

  task automatic idle(input int n, input bit rr);
    for (int i = 0; i < n; i++) step(1'b0, 4'b0000, rr);
  endtask

  // monitor: per-cycle status compare plus scoreboard pop on every newly presented code
  initial begin
    int code;
    bit newly;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        for (int k = 0; k < 3; k++) begin
          chk("valid", k, a_v[k], m_valid[k]);
          chk("multi", k, a_m[k], m_multi[k]);
          chk("drop_cnt", k, a_d[k], m_drop[k]);
          newly = (a_v[k] == 1) && (!pv[k] || ready == 1'b1);
          if (newly) begin
            if (!sb_pop(k, code)) chk("sb_unexpected_code", k, a_w[k], -1);
            else chk("w", k, a_w[k], code);
          end
          pv[k] = (a_v[k] == 1);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; e = 1'b0; y = 4'b0; ready = 1'b0;
    model_reset();
    #12;
    for (int k = 0; k < 3; k++) begin
      chk("rst_valid", k, a_v[k], 0);
      chk("rst_w", k, a_w[k], 0);
      chk("rst_multi", k, a_m[k], 0);
      chk("rst_drop", k, a_d[k], 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // single request, then multi-hot burst
    step(1'b1, 4'b0100, 1'b1); idle(2, 1'b1);
    step(1'b1, 4'b1011, 1'b1); idle(4, 1'b1);

    // round-robin wrap: grant 1, then 0011 -> 0 first, then 1001 -> 3 before 0
    step(1'b1, 4'b0010, 1'b1); idle(2, 1'b1);
    step(1'b1, 4'b0011, 1'b1); idle(3, 1'b1);
    step(1'b1, 4'b1001, 1'b1); idle(3, 1'b1);

    // backpressure, drops, saturation, re-request of held code
    step(1'b1, 4'b0011, 1'b0);
    idle(3, 1'b0);
    step(1'b1, 4'b0010, 1'b0);
    step(1'b0, 4'b0000, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 4'b0010, 1'b0);
    step(1'b1, 4'b0001, 1'b0);

    // asynchronous reset mid-hold, between clock edges
    #2;
    rst_n = 1'b0;
    e = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("arst_valid", k, a_v[k], 0);
      chk("arst_w", k, a_w[k], 0);
      chk("arst_drop", k, a_d[k], 0);
      chk("arst_multi", k, a_m[k], 0);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // first search after reset starts at index 0 in both modes
    step(1'b1, 4'b1111, 1'b1); idle(5, 1'b1);

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 2) != 0, 4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);

    idle(12, 1'b1);
    for (int k = 0; k < 3; k++) chk("sb_leftover", k, sb_size(k), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/req_encoder_4_2.md
Name: req_encoder_4_2

Overview:
- Sequential encoder for the other direction of the 2-to-4 enabled decoder path.
- Collects request lines (one-hot or multi-hot) into a sticky pending register, then emits one binary index at a time on a valid/ready handshake.
- Sits upstream of the decoder: an agent raises line y[i], this block returns code i as w.
- Used for interrupt/request funnelling where several one-hot sources must share one 2-bit code bus.

Parameters:
- N, 4: number of request lines; w width is clog2(N) (2 at default).
- MODE, 0: 0 = fixed priority (lowest index wins); 1 = round-robin (search starts after last granted index).
- CW, 4: width of the saturating drop counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- e  input  1  capture enable; y is ignored when 0.
- y  input  N  request lines; y[i] requests code i.
- ready  input  1  consumer accepts w this cycle.
- w  output  clog2(N)  encoded index, registered.
- valid  output  1  w holds a granted code, registered.
- multi  output  1  one-cycle pulse: the previous capture had more than one y bit set.
- drop_cnt  output  CW  saturating count of requests lost because the bit was already pending.

Behaviour:
- Reset (rst_n=0, asynchronous, any cycle including mid-handshake):
  - pending=0, w=0, valid=0, multi=0, drop_cnt=0.
  - Round-robin pointer last=N-1, so the first search starts at index 0.
  - All in-flight requests are discarded.
- Output slot state:
  - EMPTY (valid=0) or HOLD (valid=1).
  - In HOLD with ready=0, w and valid stay stable.
  - The slot is "free" this cycle if valid=0, or if valid=1 and ready=1.
- Grant, at each edge when the slot is free:
  - sel = priority pick from the current pending value, sampled before this edge's y.
  - If pending≠0: w←sel, valid←1, pending[sel] cleared, last←sel.
  - If pending=0: valid←0, w holds its last value.
- Priority rules:
  - MODE 0: lowest set index wins.
  - MODE 1: first set index scanning last+1, last+2, … modulo N (wrap-around from N-1 to 0).
- Capture, at each edge when e=1:
  - pending←(pending with sel cleared if granted) | y.
  - A y[i] that coincides with granting i re-sets pending[i]; this is not a drop.
  - When e=0, pending changes only by grant removal.
- Drop rule:
  - A bit counts as dropped when e=1, y[i]=1, pending[i]=1, and i is not granted on that edge.
  - drop_cnt += popcount(dropped bits), saturating at 2^CW-1 and never wrapping.
  - A request equal to the code currently held in HOLD is not a drop; it becomes pending.
- multi: registered; 1 for exactly one cycle after an edge where e=1 and popcount(y)≥2; otherwise 0.
- Latency:
  - y sampled at edge k → pending at k → valid/w at edge k+1, provided the slot is free.
  - Sustained throughput is one code per cycle while ready=1 and pending≠0.
- y=0 with e=1 is legal and has no effect. X on y while e=0 must not affect state.

Test Plan:
- Reset, then e=1, y=4'b0100 for one cycle, ready=1 → valid=1, w=2 one cycle later, then valid=0. multi=0, drop_cnt=0.
- MODE 0, e=1, y=4'b1011 for one cycle, ready=1 → multi pulses; w sequence 0,1,3 on consecutive cycles, then valid=0.
- MODE 1:
  - Grant index 1 first (y=4'b0010), then y=4'b0011 captured → next grant is w=0 (scan wraps 2,3,0).
  - Then y=4'b1001 → w=3 before 0.
- Backpressure and drops:
  - ready=0 while valid=1, w=0 → w/valid stay stable.
  - Re-request y=4'b0010 twice while bit 1 is pending → drop_cnt=1. Second-cycle e=0 with y=4'bxxxx → no change.
- Saturation and reset:
  - CW=2; force 5 drops → drop_cnt stops at 3.
  - Pulse rst_n=0 mid-HOLD, asynchronously with no clock edge → valid, w, pending and drop_cnt are all 0 immediately.
  - After release, the first grant searches from index 0.
